// File: rtl/seq_scan_scheduler.sv
// Round-robin scheduler that time-shares one serial pattern detector among several requesters.
// Words are shifted MSB first, and detector pulses in the latency-aligned window are counted.
module seq_scan_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int DET_LAT = 1,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int CNT_W   = $clog2(DATA_W + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      det_reset,
   output logic                      det_seq_in,
   input  logic                      det_detect_out,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [ID_W-1:0]           res_id,
   output logic [CNT_W-1:0]          res_count,
   output logic                      res_hit,
   output logic                      busy
);

   // state | meaning
   // IDLE  | waiting for any req_valid; grants one requester
   // RST   | one-cycle detector reset, count cleared
   // SHIFT | DATA_W cycles driving the word MSB first
   // DRAIN | DET_LAT cycles of zeros while late detections arrive
   // DONE  | result held until res_ready

   localparam int TMR_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_SHIFT,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [DATA_W-1:0]   word;
   logic [ID_W-1:0]     id_q;
   logic [CNT_W-1:0]    count;
   logic [TMR_W-1:0]    timer;

   logic [2*NUM_REQ-1:0] valid_dbl;
   logic [NUM_REQ-1:0]   valid_rot;
   logic                 grant_found;
   logic [ID_W-1:0]      grant_offs;
   logic [ID_W:0]        grant_sum;
   logic [ID_W:0]        grant_inc;
   logic [ID_W-1:0]      grant_id;
   logic [ID_W-1:0]      rr_nxt;
   logic                 timer_tc;
   logic                 sample_en;

   // Rotate the request vector so index 0 is rr_ptr, then take the first set bit.
   always_comb begin
      valid_dbl   = {req_valid, req_valid};
      valid_rot   = valid_dbl[NUM_REQ-1:0];
      valid_rot   = NUM_REQ'(valid_dbl >> rr_ptr);
      grant_found = 1'b0;
      grant_offs  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && valid_rot[k]) begin
            grant_found = 1'b1;
            grant_offs  = ID_W'(k);
         end
      end
      grant_sum = {1'b0, rr_ptr} + {1'b0, grant_offs};
      if (grant_sum >= (ID_W+1)'(NUM_REQ)) begin
         grant_sum = grant_sum - (ID_W+1)'(NUM_REQ);
      end
      grant_id  = grant_sum[ID_W-1:0];
      grant_inc = {1'b0, grant_id} + 1'b1;
      if (grant_inc == (ID_W+1)'(NUM_REQ)) begin
         rr_nxt = '0;
      end else begin
         rr_nxt = grant_inc[ID_W-1:0];
      end
   end

   assign timer_tc = (timer == '0);

   // In SHIFT the window opens DET_LAT bits after the first; DRAIN is always inside it.
   always_comb begin
      sample_en = 1'b0;
      case (state)
         S_SHIFT: sample_en = (int'(timer) + DET_LAT < DATA_W);
         S_DRAIN: sample_en = 1'b1;
         default: sample_en = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_found) state_nxt = S_RST;
         S_RST:   state_nxt = S_SHIFT;
         S_SHIFT: if (timer_tc) state_nxt = S_DRAIN;
         S_DRAIN: if (timer_tc) state_nxt = S_DONE;
         S_DONE:  if (res_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         rr_ptr <= '0;
         word   <= '0;
         id_q   <= '0;
         count  <= '0;
         timer  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (grant_found) begin
                  word   <= req_data[grant_id*DATA_W +: DATA_W];
                  id_q   <= grant_id;
                  rr_ptr <= rr_nxt;
               end
            end
            S_RST: begin
               count <= '0;
               timer <= TMR_W'(DATA_W - 1);
            end
            S_SHIFT: begin
               if (sample_en && det_detect_out) count <= count + 1'b1;
               if (timer_tc) begin
                  timer <= TMR_W'(DET_LAT - 1);
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_DRAIN: begin
               if (sample_en && det_detect_out) count <= count + 1'b1;
               if (!timer_tc) timer <= timer - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs are gated by reset so nothing leaks out during a reset cycle mid-scan.
   always_comb begin
      req_ready = '0;
      if (!reset && state == S_IDLE && grant_found) begin
         req_ready = NUM_REQ'(1) << grant_id;
      end
   end

   assign det_reset  = reset || (state == S_RST);
   assign det_seq_in = !reset && (state == S_SHIFT) && word[timer];
   assign res_valid  = !reset && (state == S_DONE);
   assign res_id     = id_q;
   assign res_count  = count;
   assign res_hit    = (count != '0);
   assign busy       = !reset && (state != S_IDLE);

endmodule

// File: tb/tb_seq_scan_scheduler.sv
// Directed bench for seq_scan_scheduler with behavioural 1011 Moore detectors,
// one DUT at DET_LAT=1 and one at DET_LAT=3.
module tb_seq_scan_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_data;
   logic        det_reset, det_seq_in, det_detect_out;
   logic        res_valid, res_ready, res_hit, busy;
   logic [1:0]  res_id;
   logic [3:0]  res_count;

   logic [3:0]  req_valid3, req_ready3;
   logic [31:0] req_data3;
   logic        det_reset3, det_seq_in3, det_detect_out3;
   logic        res_valid3, res_ready3, res_hit3, busy3;
   logic [1:0]  res_id3;
   logic [3:0]  res_count3;

   int tests = 0;
   int fails = 0;

   seq_scan_scheduler #(.NUM_REQ(4), .DATA_W(8), .DET_LAT(1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .det_reset(det_reset), .det_seq_in(det_seq_in),
      .det_detect_out(det_detect_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_id(res_id), .res_count(res_count), .res_hit(res_hit), .busy(busy));

   seq_scan_scheduler #(.NUM_REQ(4), .DATA_W(8), .DET_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid3), .req_data(req_data3),
      .req_ready(req_ready3), .det_reset(det_reset3), .det_seq_in(det_seq_in3),
      .det_detect_out(det_detect_out3), .res_valid(res_valid3), .res_ready(res_ready3),
      .res_id(res_id3), .res_count(res_count3), .res_hit(res_hit3), .busy(busy3));

   // Non-overlapping 1011 Moore detector; state 4 means detected.
   function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
      case (s)
         3'd1:    return b ? 3'd1 : 3'd2;
         3'd2:    return b ? 3'd3 : 3'd0;
         3'd3:    return b ? 3'd4 : 3'd2;
         default: return b ? 3'd1 : 3'd0;
      endcase
   endfunction

   logic [2:0] d1_st, d3_st;
   logic [1:0] d3_pipe;
   always @(posedge clk) begin
      if (det_reset) d1_st <= 3'd0;
      else           d1_st <= det_next(d1_st, det_seq_in);
   end
   assign det_detect_out = (d1_st == 3'd4);

   always @(posedge clk) begin
      if (det_reset3) begin
         d3_st   <= 3'd0;
         d3_pipe <= 2'b00;
      end else begin
         d3_st   <= det_next(d3_st, det_seq_in3);
         d3_pipe <= {d3_pipe[0], (d3_st == 3'd4)};
      end
   end
   assign det_detect_out3 = d3_pipe[1];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Offer words, capture the grant vector in the grant cycle, then advance to the RST cycle.
   task automatic start_scan(input logic [3:0] valid, input logic [31:0] data,
                             input logic hold, output logic [3:0] grant);
      req_valid = valid;
      req_data  = data;
      #1;
      grant = req_ready;
      tick();
      if (!hold) req_valid = 4'b0000;
   endtask

   // Latency is counted from the grant cycle; start_scan already consumed one cycle.
   task automatic wait_res(input int budget, output int lat, output logic saw_rdy);
      int cycles;
      cycles  = 0;
      saw_rdy = 1'b0;
      while (!res_valid && cycles < budget) begin
         if (req_ready !== 4'b0000) saw_rdy = 1'b1;
         tick();
         cycles++;
      end
      lat = cycles + 1;
   endtask

   task automatic ack;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req_valid = 4'hF;
      req_data = 32'h58FFBBB0;
      res_ready = 1'b0;
      req_valid3 = 4'h0;
      req_data3 = 32'h0;
      res_ready3 = 1'b0;
      tick();
      tick();
      tests++; if (det_reset !== 1'b1) begin fails++; $display("FAIL reset_det_reset: got %0b expected 1", det_reset); end
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %0h expected 0", req_ready); end
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      tests++; if (det_seq_in !== 1'b0) begin fails++; $display("FAIL reset_seq_in: got %0b expected 0", det_seq_in); end
      tests++; if ({res_id, res_count} !== 6'd0) begin fails++; $display("FAIL reset_res_fields: got id %0d count %0d expected 0 0", res_id, res_count); end
      req_valid = 4'h0;
      reset = 1'b0;
      tick();
      tests++; if (det_reset !== 1'b0) begin fails++; $display("FAIL idle_det_reset: got %0b expected 0", det_reset); end
   endtask

   task automatic test_single;
      logic [7:0] bits;
      logic       extra_rst;
      req_data  = 32'h000000B0;
      req_valid = 4'b0001;
      #1;
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant: got %0h expected 1", req_ready); end
      tick();
      req_valid = 4'b0000;
      tests++; if (det_reset !== 1'b1) begin fails++; $display("FAIL single_rst_cycle: got %0b expected 1", det_reset); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %0b expected 1", busy); end
      bits = 8'h00;
      extra_rst = 1'b0;
      for (int s = 0; s < 8; s++) begin
         tick();
         bits[7-s] = det_seq_in;
         if (det_reset) extra_rst = 1'b1;
      end
      tests++; if (bits !== 8'b1011_0000) begin fails++; $display("FAIL single_serial: got %b expected 10110000", bits); end
      tests++; if (extra_rst !== 1'b0) begin fails++; $display("FAIL single_rst_len: got extra det_reset %0b expected 0", extra_rst); end
      tick();
      tests++; if ({res_valid, det_seq_in} !== 2'b00) begin fails++; $display("FAIL single_drain: got valid %0b seq %0b expected 0 0", res_valid, det_seq_in); end
      tick();
      tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL single_latency: got res_valid %0b at G+11 expected 1", res_valid); end
      tests++; if ({res_id, res_count, res_hit} !== {2'd0, 4'd1, 1'b1}) begin fails++; $display("FAIL single_result: got id %0d count %0d hit %0b expected 0 1 1", res_id, res_count, res_hit); end
      ack();
      tests++; if ({res_valid, busy} !== 2'b00) begin fails++; $display("FAIL single_ack: got valid %0b busy %0b expected 0 0", res_valid, busy); end
   endtask

   task automatic test_counts;
      logic [3:0] g;
      int lat;
      logic sr;
      start_scan(4'b0100, 32'h00BB0000, 1'b0, g);
      tests++; if (g !== 4'b0100) begin fails++; $display("FAIL bb_grant: got %0h expected 4", g); end
      wait_res(40, lat, sr);
      tests++; if (lat !== 11) begin fails++; $display("FAIL bb_latency: got %0d expected 11", lat); end
      tests++; if ({res_id, res_count, res_hit} !== {2'd2, 4'd2, 1'b1}) begin fails++; $display("FAIL bb_result: got id %0d count %0d hit %0b expected 2 2 1", res_id, res_count, res_hit); end
      ack();
      start_scan(4'b0100, 32'h00FF0000, 1'b0, g);
      tests++; if (g !== 4'b0100) begin fails++; $display("FAIL ff_grant: got %0h expected 4", g); end
      wait_res(40, lat, sr);
      tests++; if ({res_valid, res_id, res_count, res_hit} !== {1'b1, 2'd2, 4'd0, 1'b0}) begin fails++; $display("FAIL ff_result: got valid %0b id %0d count %0d hit %0b expected 1 2 0 0", res_valid, res_id, res_count, res_hit); end
      ack();
   endtask

   task automatic test_back_to_back;
      logic [3:0] g;
      int lat;
      logic sr;
      int exp_id [5] = '{0, 1, 2, 3, 0};
      int exp_cnt[5] = '{1, 2, 0, 1, 1};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start_scan(4'hF, 32'h58FFBBB0, 1'b1, g);
         tests++; if (g !== (4'b0001 << exp_id[i])) begin fails++; $display("FAIL rr_grant_%0d: got %0h expected %0h", i, g, 4'b0001 << exp_id[i]); end
         wait_res(40, lat, sr);
         tests++; if (sr !== 1'b0) begin fails++; $display("FAIL rr_busy_ready_%0d: got %0b expected 0", i, sr); end
         tests++; if ({res_valid, res_id, res_count} !== {1'b1, 2'(exp_id[i]), 4'(exp_cnt[i])}) begin fails++; $display("FAIL rr_result_%0d: got valid %0b id %0d count %0d expected 1 %0d %0d", i, res_valid, res_id, res_count, exp_id[i], exp_cnt[i]); end
         ack();
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_fairness;
      logic [3:0] g;
      int lat;
      logic sr;
      start_scan(4'b1000, 32'h58000000, 1'b0, g);
      tests++; if (g !== 4'b1000) begin fails++; $display("FAIL fair_first: got %0h expected 8", g); end
      wait_res(40, lat, sr);
      tests++; if ({res_id, res_count} !== {2'd3, 4'd1}) begin fails++; $display("FAIL fair_first_res: got id %0d count %0d expected 3 1", res_id, res_count); end
      ack();
      start_scan(4'b1001, 32'h580000B0, 1'b0, g);
      tests++; if (g !== 4'b0001) begin fails++; $display("FAIL fair_wrap: got %0h expected 1", g); end
      wait_res(40, lat, sr);
      tests++; if ({res_id, res_count} !== {2'd0, 4'd1}) begin fails++; $display("FAIL fair_wrap_res: got id %0d count %0d expected 0 1", res_id, res_count); end
      ack();
   endtask

   task automatic test_reset_mid_scan;
      logic [3:0] g;
      int lat;
      logic sr;
      start_scan(4'b0010, 32'h0000BB00, 1'b0, g);
      for (int s = 0; s <= 6; s++) tick();
      reset = 1'b1;
      #1;
      tests++; if ({det_reset, det_seq_in, res_valid} !== 3'b100) begin fails++; $display("FAIL mid_reset_outputs: got rst %0b seq %0b valid %0b expected 1 0 0", det_reset, det_seq_in, res_valid); end
      tick();
      reset = 1'b0;
      #1;
      tests++; if ({busy, res_valid, res_count} !== 6'd0) begin fails++; $display("FAIL mid_reset_idle: got busy %0b valid %0b count %0d expected 0 0 0", busy, res_valid, res_count); end
      start_scan(4'b1010, 32'hB000FF00, 1'b0, g);
      tests++; if (g !== 4'b0010) begin fails++; $display("FAIL mid_reset_rrptr: got %0h expected 2", g); end
      wait_res(40, lat, sr);
      tests++; if (lat !== 11) begin fails++; $display("FAIL mid_reset_latency: got %0d expected 11", lat); end
      tests++; if ({res_id, res_count, res_hit} !== {2'd1, 4'd0, 1'b0}) begin fails++; $display("FAIL mid_reset_result: got id %0d count %0d hit %0b expected 1 0 0", res_id, res_count, res_hit); end
      ack();
   endtask

   task automatic test_hold_done;
      logic [3:0] g;
      int lat;
      logic sr, bad_valid, bad_fields, bad_ready;
      start_scan(4'b0001, 32'h000000BB, 1'b0, g);
      wait_res(40, lat, sr);
      req_valid = 4'b1110;
      req_data  = 32'hB0B0B000;
      bad_valid = 1'b0; bad_fields = 1'b0; bad_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (res_valid !== 1'b1) bad_valid = 1'b1;
         if ({res_id, res_count, res_hit} !== {2'd0, 4'd2, 1'b1}) bad_fields = 1'b1;
         if (req_ready !== 4'b0000) bad_ready = 1'b1;
         tick();
      end
      tests++; if (bad_valid !== 1'b0) begin fails++; $display("FAIL hold_valid: got drop %0b expected 0", bad_valid); end
      tests++; if (bad_fields !== 1'b0) begin fails++; $display("FAIL hold_fields: got change %0b expected 0 (id %0d count %0d)", bad_fields, res_id, res_count); end
      tests++; if (bad_ready !== 1'b0) begin fails++; $display("FAIL hold_no_grant: got ready seen %0b expected 0", bad_ready); end
      req_valid = 4'b0000;
      ack();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_release: got busy %0b expected 0", busy); end
   endtask

   task automatic test_det_lat3;
      int cycles;
      req_valid3 = 4'b0001;
      req_data3  = 32'h000000B0;
      #1;
      tests++; if (req_ready3 !== 4'b0001) begin fails++; $display("FAIL lat3_grant: got %0h expected 1", req_ready3); end
      tick();
      req_valid3 = 4'b0000;
      cycles = 1;
      while (!res_valid3 && cycles < 40) begin
         tick();
         cycles++;
      end
      tests++; if (cycles !== 13) begin fails++; $display("FAIL lat3_latency: got %0d expected 13", cycles); end
      tests++; if ({res_id3, res_count3, res_hit3} !== {2'd0, 4'd1, 1'b1}) begin fails++; $display("FAIL lat3_result: got id %0d count %0d hit %0b expected 0 1 1", res_id3, res_count3, res_hit3); end
      res_ready3 = 1'b1;
      tick();
      res_ready3 = 1'b0;
      tests++; if (res_valid3 !== 1'b0) begin fails++; $display("FAIL lat3_ack: got %0b expected 0", res_valid3); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_counts();
      test_back_to_back();
      test_fairness();
      test_reset_mid_scan();
      test_hold_done();
      test_det_lat3();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
